// File: rtl/mmem_write_buffer_if.sv
// Bus between the pipeline/RAM side and the M-memory write buffer.
interface mmem_write_buffer_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_c;
  logic          rd_valid_c;
  logic          busy;
  logic [AW-1:0] ram_a_c;
  logic [DW-1:0] ram_di_c;
  logic          ram_ce_n_c;
  logic          ram_we_n_c;
  logic [DW-1:0] ram_do;

  // Pipeline plus RAM side: issues requests, returns RAM read data.
  modport master (
    output wr_req, wr_addr, wr_data, rd_en, rd_addr, ram_do,
    input  rd_data_c, rd_valid_c, busy, ram_a_c, ram_di_c, ram_ce_n_c, ram_we_n_c
  );

  // Write buffer side.
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_en, rd_addr, ram_do,
    output rd_data_c, rd_valid_c, busy, ram_a_c, ram_di_c, ram_ce_n_c, ram_we_n_c
  );
endinterface

// File: rtl/mmem_write_buffer.sv
// Write buffer in front of the M-memory RAM: queues writes, drains them when the
// shared RAM port is idle, forwards queued data to reads, clears the RAM after reset.
module mmem_write_buffer #(
  parameter int unsigned AW             = 5,
  parameter int unsigned DW             = 32,
  parameter int unsigned DEPTH          = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  mmem_write_buffer_if.slave bus
);

  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [AW-1:0] CNT_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic          busy_q;
  logic [AW-1:0] cnt_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          run, push, drain;
  logic [CW-1:0] wr_idx;
  logic          byp_hit, buf_hit, rd_ok;
  logic [DW-1:0] buf_data;

  assign bus.busy = busy_q;

  // State, clear counter and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      busy_q  <= CLEAR_ON_RESET;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_INIT);
      if (state_q == S_INIT) cnt_q <= cnt_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(drain);
    end
  end

  // FIFO storage, index 0 is the oldest entry; shift on pop, then write the new tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (drain) begin
        addr_q[i] <= addr_q[i+1];
        data_q[i] <= data_q[i+1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && (wr_idx == CW'(i))) begin
        addr_q[i] <= bus.wr_addr;
        data_q[i] <= bus.wr_data;
      end
    end
  end

  // Drain decision and forwarding lookup against the pre-pop buffer contents.
  always_comb begin
    run      = (state_q == S_RUN);
    push     = run && bus.wr_req;
    drain    = run && (count_q != '0) && (!bus.rd_en || (count_q == FULL));
    wr_idx   = count_q - CW'(drain);
    byp_hit  = bus.wr_req && (bus.wr_addr == bus.rd_addr);
    buf_hit  = 1'b0;
    buf_data = '0;
    // Later (newer) entries override earlier ones.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(i) < count_q) && (addr_q[i] == bus.rd_addr)) begin
        buf_hit  = 1'b1;
        buf_data = data_q[i];
      end
    end
  end

  // Next state, RAM port mux and read result.
  always_comb begin
    state_d        = state_q;
    rd_ok          = 1'b0;
    bus.ram_a_c    = bus.rd_addr;
    bus.ram_di_c   = '0;
    bus.ram_ce_n_c = 1'b1;
    bus.ram_we_n_c = 1'b1;
    bus.rd_valid_c = 1'b0;
    bus.rd_data_c  = '0;
    if (rst_n) begin
      case (state_q)
        S_INIT: begin
          bus.ram_a_c    = cnt_q;
          bus.ram_ce_n_c = 1'b0;
          bus.ram_we_n_c = 1'b0;
          if (cnt_q == CNT_MAX) state_d = S_RUN;
        end
        S_RUN: begin
          if (drain) begin
            bus.ram_a_c    = addr_q[0];
            bus.ram_di_c   = data_q[0];
            bus.ram_ce_n_c = 1'b0;
            bus.ram_we_n_c = 1'b0;
          end else begin
            bus.ram_ce_n_c = !bus.rd_en;
          end
          rd_ok          = bus.rd_en && (!drain || byp_hit || buf_hit);
          bus.rd_valid_c = rd_ok;
          if (rd_ok) begin
            if (byp_hit)      bus.rd_data_c = bus.wr_data;
            else if (buf_hit) bus.rd_data_c = buf_data;
            else              bus.rd_data_c = bus.ram_do;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

endmodule
